// File: rtl/anim_pkg.sv
// Shared encodings for the sprite animation frame sequencer.
package anim_pkg;

  typedef enum logic [1:0] {
    ANIM_ONCE     = 2'b00,
    ANIM_LOOP     = 2'b01,
    ANIM_PINGPONG = 2'b10
  } anim_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } anim_state_e;

  // Map the raw mode field to the playback behaviour actually built in.
  function automatic anim_mode_e decode_mode(input logic [1:0] mode, input logic pingpong_en);
    case (mode)
      2'b00:   decode_mode = ANIM_ONCE;
      2'b10:   decode_mode = pingpong_en ? ANIM_PINGPONG : ANIM_LOOP;
      default: decode_mode = ANIM_LOOP;
    endcase
  endfunction

endpackage

// File: rtl/anim_tick_div.sv
// Tick divider: emits a same-cycle advance pulse on every (limit+1)-th qualified tick.
module anim_tick_div
  import anim_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [DIV_WIDTH-1:0] limit,
  output logic                 adv_c
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign adv_c = tick && (cnt_q == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= adv_c ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/anim_frame_sequencer.sv
// Sprite frame sequencer stepping a frame index on divided counter ticks.
// Define ANIM_PINGPONG_EN to build ping-pong playback (mode 10); otherwise mode 10 loops.
module anim_frame_sequencer
  import anim_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WIDTH-1:0]     first_frame,
  input  logic [WIDTH-1:0]     last_frame,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] ticks_per_frame,
  output logic [WIDTH-1:0]     frame,
  output logic                 frame_stb,
  output logic                 busy,
  output logic                 done
);

`ifdef ANIM_PINGPONG_EN
  localparam logic PINGPONG_EN = 1'b1;
`else
  localparam logic PINGPONG_EN = 1'b0;
`endif

  anim_state_e          state_q, state_d;
  anim_mode_e           mode_q;
  logic [WIDTH-1:0]     first_q, last_q, frame_q, frame_d;
  logic [DIV_WIDTH-1:0] tpf_q;
  logic                 stb_q, stb_d, done_q, done_d, busy_q;
  logic                 div_clear, div_tick, adv, degenerate;
`ifdef ANIM_PINGPONG_EN
  logic                 down_q, down_d;
`endif

  assign degenerate = (first_q >= last_q);
  assign div_clear  = start || stop;
  // Ticks coinciding with start/stop or arriving in IDLE never reach the divider.
  assign div_tick   = tick && (state_q == ST_RUN) && !start && !stop;

  anim_tick_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (div_tick),
    .limit (tpf_q),
    .adv_c (adv)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q <= '0;
      last_q  <= '0;
      tpf_q   <= '0;
      mode_q  <= ANIM_ONCE;
    end else if (start) begin
      first_q <= first_frame;
      last_q  <= last_frame;
      tpf_q   <= ticks_per_frame;
      mode_q  <= decode_mode(mode, PINGPONG_EN);
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    down_d  = down_q;
`endif
    if (start) begin
      state_d = ST_RUN;
      frame_d = first_frame;
      stb_d   = 1'b1;
`ifdef ANIM_PINGPONG_EN
      down_d  = 1'b0;
`endif
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (adv) begin
      case (mode_q)
        ANIM_ONCE: begin
          if (frame_q < last_q) begin
            frame_d = frame_q + WIDTH'(1);
            stb_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
`ifdef ANIM_PINGPONG_EN
        ANIM_PINGPONG: begin
          if (!degenerate) begin
            stb_d = 1'b1;
            if (!down_q) begin
              if (frame_q == last_q) begin
                down_d  = 1'b1;
                frame_d = frame_q - WIDTH'(1);
              end else begin
                frame_d = frame_q + WIDTH'(1);
              end
            end else begin
              if (frame_q == first_q) begin
                down_d  = 1'b0;
                frame_d = frame_q + WIDTH'(1);
              end else begin
                frame_d = frame_q - WIDTH'(1);
              end
            end
          end
        end
`endif
        default: begin
          if (!degenerate) begin
            stb_d   = 1'b1;
            frame_d = (frame_q == last_q) ? first_q : frame_q + WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ST_RUN);
    end
  end

`ifdef ANIM_PINGPONG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      down_q <= 1'b0;
    end else begin
      down_q <= down_d;
    end
  end
`endif

  assign frame     = frame_q;
  assign frame_stb = stb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Scoreboard bench for anim_frame_sequencer against a playlist-based reference model.
module tb_anim_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] first_frame = '0, last_frame = '0, ticks_per_frame = '0;
  logic [1:0] mode = '0;
  logic [3:0] frame;
  logic       frame_stb, busy, done;

  always #5 clk = ~clk;

  anim_frame_sequencer #(.WIDTH(4), .DIV_WIDTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .start           (start),
    .stop            (stop),
    .first_frame     (first_frame),
    .last_frame      (last_frame),
    .mode            (mode),
    .ticks_per_frame (ticks_per_frame),
    .frame           (frame),
    .frame_stb       (frame_stb),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    bit is_done;
    int fr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model: the whole playback is a precomputed playlist walked one entry per advance.
  int  seq[$];
  int  pos = 0, cnt = 0, m_tpf = 0;
  bit  m_once = 1'b0, m_run = 1'b0;
  int  exp_frame = 0;
  bit  exp_busy = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input bit is_done, input int fr);
    ev_t e;
    e.is_done = is_done;
    e.fr      = fr;
    exp_q.push_back(e);
  endtask

  task automatic model_start(input int ff, input int lf, input int md, input int tpf);
    bit pp;
    pp = 1'b0;
`ifdef ANIM_PINGPONG_EN
    pp = (md == 2);
`endif
    seq.delete();
    m_tpf  = tpf;
    m_once = (md == 0);
    if (ff >= lf) begin
      seq.push_back(ff);
    end else begin
      for (int f = ff; f <= lf; f++) seq.push_back(f);
      if (pp) for (int f = lf - 1; f > ff; f--) seq.push_back(f);
    end
    pos       = 0;
    cnt       = 0;
    m_run     = 1'b1;
    exp_busy  = 1'b1;
    exp_frame = seq[0];
    push_ev(1'b0, exp_frame);
  endtask

  task automatic model_step(input bit t, input bit s, input bit p,
                            input int ff, input int lf, input int md, input int tpf);
    if (s) begin
      model_start(ff, lf, md, tpf);
    end else if (p) begin
      m_run    = 1'b0;
      exp_busy = 1'b0;
      cnt      = 0;
    end else if (m_run && t) begin
      if (cnt == m_tpf) begin
        cnt = 0;
        if (m_once) begin
          if (pos < seq.size() - 1) begin
            pos++;
            exp_frame = seq[pos];
            push_ev(1'b0, exp_frame);
          end else begin
            m_run    = 1'b0;
            exp_busy = 1'b0;
            push_ev(1'b1, exp_frame);
          end
        end else if (seq.size() > 1) begin
          pos       = (pos + 1) % seq.size();
          exp_frame = seq[pos];
          push_ev(1'b0, exp_frame);
        end
      end else begin
        cnt++;
      end
    end
  endtask

  task automatic drive(input bit t, input bit s, input bit p,
                       input int ff, input int lf, input int md, input int tpf);
    @(negedge clk);
    tick            = t;
    start           = s;
    stop            = p;
    first_frame     = 4'(ff);
    last_frame      = 4'(lf);
    mode            = 2'(md);
    ticks_per_frame = 4'(tpf);
    model_step(t, s, p, ff, lf, md, tpf);
  endtask

  // Non-start cycles carry random configuration to show it is ignored.
  task automatic ticks(input int n, input bit t);
    for (int i = 0; i < n; i++)
      drive(t, 1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3), $urandom_range(0, 15));
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    m_run     = 1'b0;
    cnt       = 0;
    exp_frame = 0;
    exp_busy  = 1'b0;
    #1;
    check("async_reset_frame", frame, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_stb", frame_stb, 0);
    check("async_reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares state every cycle and pops the scoreboard on each output event.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      check("frame", frame, exp_frame);
      check("busy", busy, exp_busy);
      check("event_present", int'(frame_stb || done), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (frame_stb || done) begin
          check("event_done", done, e.is_done);
          check("event_stb", frame_stb, !e.is_done);
          if (!e.is_done) check("stb_frame", frame, e.fr);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_frame", frame, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stb", frame_stb, 0);
    reset = 1'b0;

    ticks(4, 1'b1);

    // Once mode 2..5, advance every second tick, completes on the 8th tick.
    drive(1'b0, 1'b1, 1'b0, 2, 5, 0, 1);
    ticks(8, 1'b1);
    ticks(3, 1'b1);

    // Loop mode 0..3, advance every tick.
    drive(1'b0, 1'b1, 1'b0, 0, 3, 1, 0);
    ticks(10, 1'b1);

    // Mode 10 on 0..3: ping-pong when built in, loop otherwise.
    drive(1'b0, 1'b1, 1'b0, 0, 3, 2, 0);
    ticks(8, 1'b1);

    // Stop in loop mode while frame is 2.
    drive(1'b0, 1'b1, 1'b0, 0, 3, 1, 0);
    for (int i = 0; i < 8 && exp_frame != 2; i++) ticks(1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    ticks(5, 1'b1);

    // Degenerate ranges and mode 11.
    drive(1'b0, 1'b1, 1'b0, 7, 7, 1, 0);
    ticks(4, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 9, 4, 0, 0);
    ticks(3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 12, 15, 3, 0);
    ticks(6, 1'b1);

    // Restart with tick and stop in the same cycle, then reset mid-run.
    drive(1'b1, 1'b1, 1'b0, 5, 9, 1, 0);
    ticks(3, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 3, 6, 1, 0);
    ticks(2, 1'b1);
    do_reset();
    ticks(4, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 2, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    ticks(3, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
